// File: rtl/pvr_vram_arb_if.sv
// pvr_vram_arb_if: requester and VRAM port signals shared by the PVR VRAM arbiter.
interface pvr_vram_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic ra_req, isp_req, tex_req;
  logic ra_we, isp_we, tex_we;
  logic [ADDR_W-1:0] ra_addr, isp_addr, tex_addr;
  logic [DATA_W-1:0] ra_wdata, isp_wdata, tex_wdata;
  logic ra_gnt, isp_gnt, tex_gnt;
  logic ra_rvalid, isp_rvalid, tex_rvalid;
  logic [DATA_W-1:0] ra_rdata, isp_rdata, tex_rdata;
  logic mem_rd, mem_wr, mem_ready, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master (
    output ra_req, isp_req, tex_req, ra_we, isp_we, tex_we,
           ra_addr, isp_addr, tex_addr, ra_wdata, isp_wdata, tex_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  ra_gnt, isp_gnt, tex_gnt, ra_rvalid, isp_rvalid, tex_rvalid,
           ra_rdata, isp_rdata, tex_rdata, mem_rd, mem_wr, mem_addr, mem_wdata
  );
  modport slave (
    input  ra_req, isp_req, tex_req, ra_we, isp_we, tex_we,
           ra_addr, isp_addr, tex_addr, ra_wdata, isp_wdata, tex_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output ra_gnt, isp_gnt, tex_gnt, ra_rvalid, isp_rvalid, tex_rvalid,
           ra_rdata, isp_rdata, tex_rdata, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pvr_vram_arb.sv
// pvr_vram_arb: round-robin arbiter sharing the single PVR VRAM port among ra, isp and tex.
module pvr_vram_arb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pvr_vram_arb_if.slave bus,
  output logic          orphan_err_o
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, WDONE = 2'd3;
  logic [2:0] req, we;
  logic [ADDR_W-1:0] addr [3];
  logic [DATA_W-1:0] wdata [3];
  logic [1:0] state_q, state_d, ptr_q, ptr_d, own_q, own_d, idx1, idx2, win;
  logic we_q, we_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, orphan_q, orphan_d;
  logic take, accept, rd_done;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q [3];
  logic [DATA_W-1:0] rdata_d [3];
  assign req = {bus.tex_req, bus.isp_req, bus.ra_req};
  assign we = {bus.tex_we, bus.isp_we, bus.ra_we};
  assign addr[0] = bus.ra_addr;
  assign addr[1] = bus.isp_addr;
  assign addr[2] = bus.tex_addr;
  assign wdata[0] = bus.ra_wdata;
  assign wdata[1] = bus.isp_wdata;
  assign wdata[2] = bus.tex_wdata;
  always_comb begin
    idx1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    idx2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    win = req[ptr_q] ? ptr_q : req[idx1] ? idx1 : idx2;
    // the cycle carrying a read's rvalid pulse is not a sampling cycle
    take = state_q == IDLE && |req && ~|rvalid_q;
    accept = state_q == ISSUE && bus.mem_ready;
    rd_done = state_q == WAIT_RD && bus.mem_rvalid;
    state_d = take ? ISSUE : accept ? (we_q ? WDONE : WAIT_RD) :
              (rd_done || state_q == WDONE) ? IDLE : state_q;
    own_d = take ? win : own_q;
    we_d = take ? we[win] : we_q;
    addr_d = take ? addr[win] : addr_q;
    wdata_d = take ? wdata[win] : wdata_q;
    ptr_d = accept ? ((own_q == 2'd2) ? 2'd0 : own_q + 2'd1) : ptr_q;
    gnt_d = accept ? 3'd1 << own_q : 3'd0;
    rvalid_d = rd_done ? 3'd1 << own_q : 3'd0;
    for (int i = 0; i < 3; i++) rdata_d[i] = (rd_done && own_q == 2'(i)) ? bus.mem_rdata : rdata_q[i];
    mem_rd_d = state_d == ISSUE && !we_d;
    mem_wr_d = state_d == ISSUE && we_d;
    orphan_d = orphan_q || (bus.mem_rvalid && state_q != WAIT_RD);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q <= 2'd0;
      own_q <= 2'd0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      gnt_q <= 3'd0;
      rvalid_q <= 3'd0;
      rdata_q <= '{default: '0};
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      orphan_q <= orphan_d;
    end
  end
  assign {bus.tex_gnt, bus.isp_gnt, bus.ra_gnt} = gnt_q;
  assign {bus.tex_rvalid, bus.isp_rvalid, bus.ra_rvalid} = rvalid_q;
  assign bus.ra_rdata = rdata_q[0];
  assign bus.isp_rdata = rdata_q[1];
  assign bus.tex_rdata = rdata_q[2];
  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_wr = mem_wr_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign orphan_err_o = orphan_q;
endmodule
